// File: rtl/vga_pkg.sv
// Shared constants and types for the plot stream: frame store geometry,
// 640x480@60 timing and the pixel record passed between graphics units.
package vga_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_ADDR_W = 17;
  localparam int FB_DEPTH  = FB_W * FB_H;
  localparam int COLOUR_W  = 3;

  localparam int VGA_CLK_DIV = 2;
  localparam int VGA_H_VIS   = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_V_VIS   = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 33;

  typedef struct packed {
    logic [8:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // y*320 + x built from shifts so no multiplier is inferred
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [8:0] x, input logic [7:0] y);
    logic [FB_ADDR_W-1:0] yw;
    logic [FB_ADDR_W-1:0] xw;
    yw = {9'd0, y};
    xw = {8'd0, x};
    return (yw << 8) + (yw << 6) + xw;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// 320x240x3 frame store: one write port, one synchronous read port,
// read returns the previous contents on a same-address collision.
module frame_ram
  import vga_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [FB_ADDR_W-1:0] waddr,
  input  logic [COLOUR_W-1:0]  wdata,
  input  logic [FB_ADDR_W-1:0] raddr,
  output logic [COLOUR_W-1:0]  rdata
);

  logic [COLOUR_W-1:0] mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_scanout.sv
// Pixel sink and VGA scan-out: accepts plot writes into the frame store and
// scans it out at 640x480 with every stored pixel doubled in both directions.
module frame_scanout
  import vga_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV,
  parameter int H_VIS   = VGA_H_VIS,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BP    = VGA_H_BP,
  parameter int V_VIS   = VGA_V_VIS,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BP    = VGA_V_BP
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [8:0]          x_in,
  input  logic [7:0]          y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                writeEn,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_blank_n,
  output logic                vga_sync_n,
  output logic                vga_clk,
  output logic                frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]     div;
  logic                 tick;
  logic [9:0]           hcnt;
  logic [9:0]           vcnt;
  logic                 h_end;
  logic                 v_end;
  logic                 wrap;
  logic                 visible;
  logic                 hs_n;
  logic                 vs_n;
  logic                 wr_ok;
  logic [FB_ADDR_W-1:0] waddr;
  logic [FB_ADDR_W-1:0] raddr;
  logic [COLOUR_W-1:0]  rdata;
  logic                 s1_vis;
  logic                 s1_hs;
  logic                 s1_vs;

  assign tick    = (div == DIV_W'(CLK_DIV - 1));
  assign h_end   = (hcnt == 10'(H_TOTAL - 1));
  assign v_end   = (vcnt == 10'(V_TOTAL - 1));
  assign wrap    = tick & h_end & v_end;
  assign vga_clk = (div >= DIV_W'(CLK_DIV / 2));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      if (h_end) begin
        hcnt <= '0;
        vcnt <= v_end ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign visible = (hcnt < 10'(H_VIS)) && (vcnt < 10'(V_VIS));
  assign hs_n    = !((hcnt >= 10'(H_VIS + H_FP)) && (hcnt < 10'(H_VIS + H_FP + H_SYNC)));
  assign vs_n    = !((vcnt >= 10'(V_VIS + V_FP)) && (vcnt < 10'(V_VIS + V_FP + V_SYNC)));

  assign wr_ok = writeEn && (x_in < 9'(FB_W)) && (y_in < 8'(FB_H));
  assign waddr = fb_addr(x_in, y_in);
  // outside the visible window the read is parked on address 0 so it never leaves the store
  assign raddr = visible ? fb_addr(hcnt[9:1], vcnt[8:1]) : '0;

  frame_ram u_frame_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (waddr),
    .wdata (colour_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_vis <= 1'b0;
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
    end else begin
      s1_vis <= visible;
      s1_hs  <= hs_n;
      s1_vs  <= vs_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= s1_vis ? {8{rdata[2]}} : 8'd0;
      vga_g       <= s1_vis ? {8{rdata[1]}} : 8'd0;
      vga_b       <= s1_vis ? {8{rdata[0]}} : 8'd0;
      vga_hs      <= s1_hs;
      vga_vs      <= s1_vs;
      vga_blank_n <= s1_vis;
      frame_start <= wrap;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout: random plot writes against a time-indexed model of
// the scan, plus measured sync/frame timing. Vertical timing is shortened.
module tb_frame_scanout;

  localparam int CD = 2;
  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 8, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int LINE_CLK  = CD * HT;
  localparam int FRAME_CLK = LINE_CLK * VT;

  logic       clk = 1'b0;
  logic       resetn;
  logic [8:0] x_in;
  logic [7:0] y_in;
  logic [2:0] colour_in;
  logic       writeEn;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;

  always #5 clk = ~clk;

  frame_scanout #(
    .CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .x_in        (x_in),
    .y_in        (y_in),
    .colour_in   (colour_in),
    .writeEn     (writeEn),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_sync_n  (vga_sync_n),
    .vga_clk     (vga_clk),
    .frame_start (frame_start)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       vis;
    logic       hs;
    logic       vs;
    logic [2:0] col;
    logic       known;
  } exp_t;

  localparam exp_t RST_EXP = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, col: 3'd0, known: 1'b1};

  // model: frame store contents plus the scan position as a function of clocks since release
  logic [2:0] m_mem   [76800];
  bit         m_known [76800];
  int         s_idx    = 0;
  int         cyc      = 0;
  int         rel_cyc  = 0;
  bit         model_on = 0;
  exp_t       e_s1     = RST_EXP;
  exp_t       e_out    = RST_EXP;
  logic       e_fs     = 1'b0;
  logic       e_vclk   = 1'b0;

  function automatic int cur_h();
    return ((s_idx / CD) % (HT * VT)) % HT;
  endfunction

  function automatic int cur_v();
    return ((s_idx / CD) % (HT * VT)) / HT;
  endfunction

  always @(posedge clk) begin
    int   pix, h, v, a;
    exp_t nxt;
    cyc++;
    model_on = 1;
    if (!resetn) begin
      rel_cyc = cyc;
      s_idx   = 0;
      e_s1    = RST_EXP;
      e_out   = RST_EXP;
      e_fs    = 1'b0;
      e_vclk  = 1'b0;
    end else begin
      pix = (s_idx / CD) % (HT * VT);
      h   = pix % HT;
      v   = pix / HT;
      nxt.vis = (h < HV) && (v < VV);
      nxt.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
      nxt.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
      if (nxt.vis) begin
        a         = (v / 2) * 320 + h / 2;
        nxt.col   = m_mem[a];
        nxt.known = m_known[a];
      end else begin
        nxt.col   = 3'd0;
        nxt.known = 1'b1;
      end
      e_out = e_s1;
      e_s1  = nxt;
      e_fs  = (s_idx % FRAME_CLK) == FRAME_CLK - 1;
      s_idx++;
      e_vclk = (s_idx % CD) >= CD / 2;
    end
    if (writeEn && x_in < 320 && y_in < 240) begin
      a          = int'(y_in) * 320 + int'(x_in);
      m_mem[a]   = colour_in;
      m_known[a] = 1'b1;
    end
  end

  int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_q[$];
  logic prev_hs = 1'b1;
  logic prev_vs = 1'b1;

  always @(negedge clk) begin
    if (model_on) begin
      check_eq("sync_pins",
               {58'd0, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start},
               {58'd0, e_out.hs, e_out.vs, e_out.vis, 1'b0, e_vclk, e_fs});
      if (e_out.known)
        check_eq("rgb", {40'd0, vga_r, vga_g, vga_b},
                 {40'd0, {8{e_out.col[2]}}, {8{e_out.col[1]}}, {8{e_out.col[0]}}});
      if (prev_hs && !vga_hs) hs_fall.push_back(cyc);
      if (!prev_hs && vga_hs) hs_rise.push_back(cyc);
      if (prev_vs && !vga_vs) vs_fall.push_back(cyc);
      if (!prev_vs && vga_vs) vs_rise.push_back(cyc);
      if (frame_start) fs_q.push_back(cyc);
      prev_hs = vga_hs;
      prev_vs = vga_vs;
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int x, input int y, input int c);
    writeEn   = 1'b1;
    x_in      = 9'(x);
    y_in      = 8'(y);
    colour_in = 3'(c);
    clk_wait(1);
    writeEn   = 1'b0;
  endtask

  initial begin
    int guard, rel1, fs_before, first_after;
    logic [2:0] newc;
    resetn = 1'b0; writeEn = 1'b0; x_in = '0; y_in = '0; colour_in = '0;
    clk_wait(5);
    check_eq("reset_outputs",
             {35'd0, vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start, vga_r, vga_g, vga_b},
             {35'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0});
    resetn = 1'b1;

    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 320; x++)
        wr(x, y, int'($urandom_range(0, 7)));

    repeat (12000) begin
      if ($urandom_range(0, 3) == 0) begin
        writeEn   = 1'b1;
        x_in      = 9'($urandom_range(0, 340));
        y_in      = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
        colour_in = 3'($urandom_range(0, 7));
      end else begin
        writeEn = 1'b0;
      end
      clk_wait(1);
    end
    writeEn = 1'b0;

    // directed pattern lands in the blanked tail of frame 1 and is shown in frame 2
    wr(0, 0, 0);
    wr(0, 1, 0);
    wr(320, 0, 7);
    wr(0, 240, 7);
    wr(0, 0, 3'b100);
    wr(1, 0, 3'b010);
    wr(319, 3, 7);

    guard = 0;
    while (!(cur_h() == 20 && cur_v() == 0 && (s_idx % CD) == 0) && guard <= FRAME_CLK) begin
      clk_wait(1);
      guard++;
    end
    check_eq("collision_wait", {63'd0, guard <= FRAME_CLK}, 64'd1);
    newc = m_mem[10] ^ 3'b101;
    wr(10, 0, int'(newc));

    clk_wait(2 * FRAME_CLK + 5 * LINE_CLK + 100 - s_idx);
    rel1 = rel_cyc;
    resetn = 1'b0;
    clk_wait(3);
    fs_before = fs_q.size();
    resetn = 1'b1;
    clk_wait(2 * LINE_CLK + 100);
    check_eq("no_fs_after_reset", 64'(fs_q.size() - fs_before), 64'd0);

    first_after = -1;
    foreach (hs_fall[i])
      if (first_after < 0 && hs_fall[i] > rel_cyc) first_after = hs_fall[i];
    check_eq("hs_fall_after_reset", 64'(first_after - rel_cyc), 64'(CD * (HV + HF) + 2));

    check_eq("hs_edges_seen", {63'd0, hs_fall.size() >= 2 && hs_rise.size() >= 1}, 64'd1);
    if (hs_fall.size() >= 2 && hs_rise.size() >= 1) begin
      check_eq("first_hs_fall", 64'(hs_fall[0] - rel1), 64'(CD * (HV + HF) + 2));
      check_eq("hs_low_width", 64'(hs_rise[0] - hs_fall[0]), 64'(CD * HS));
      check_eq("line_period", 64'(hs_fall[1] - hs_fall[0]), 64'(LINE_CLK));
    end
    check_eq("vs_edges_seen", {63'd0, vs_fall.size() >= 1 && vs_rise.size() >= 1}, 64'd1);
    if (vs_fall.size() >= 1 && vs_rise.size() >= 1) begin
      check_eq("vs_start", 64'(vs_fall[0] - rel1), 64'(LINE_CLK * (VV + VF) + 2));
      check_eq("vs_low_width", 64'(vs_rise[0] - vs_fall[0]), 64'(LINE_CLK * VS));
    end
    check_eq("fs_seen", {63'd0, fs_before >= 2}, 64'd1);
    if (fs_before >= 2) begin
      check_eq("first_frame_start", 64'(fs_q[0] - rel1), 64'(FRAME_CLK));
      check_eq("frame_period", 64'(fs_q[1] - fs_q[0]), 64'(FRAME_CLK));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
